// File: rtl/outhex32_1_1_32.sv
// Prints a 32-bit word as NDIGITS uppercase ASCII hex digits (optionally CR LF) into a byte transmitter.
// First byte_start one cycle after an accepted start; each byte holds in WAIT until byte_ready, with no timeout.
module outhex32_1_1_32 #(
   parameter int NDIGITS     = 8,
   parameter int APPEND_CRLF = 1,
   parameter int SUPPRESS_LZ = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] value,
   output logic [3:0]  result,
   output logic        result_ready,
   output logic        byte_start,
   output logic [7:0]  byte_out,
   input  logic        byte_ready
);

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   // Item index: 0..NDIGITS-1 are digits, then CR, then LF.
   localparam logic [3:0] LAST_DIG  = 4'(NDIGITS - 1);
   localparam logic [3:0] CR_IDX    = 4'(NDIGITS);
   localparam logic [3:0] FINAL_IDX = (APPEND_CRLF != 0) ? 4'(NDIGITS + 1) : 4'(NDIGITS - 1);
   localparam logic       SLZ       = (SUPPRESS_LZ != 0);

   state_t      state, state_nxt;
   logic [31:0] shreg;
   logic [3:0]  idx;
   logic [3:0]  cnt;
   logic        seen;
   logic [7:0]  byte_q;
   logic [3:0]  digit;
   logic        is_digit;
   logic        skip;
   logic [7:0]  cur_byte;

   // The digit being considered always sits in the top nibble of the printed field.
   assign digit    = shreg[4*NDIGITS-1 -: 4];
   assign is_digit = (idx < CR_IDX);
   assign skip     = SLZ && is_digit && (digit == 4'h0) && !seen && (idx != LAST_DIG);

   always_comb begin
      cur_byte = 8'h0A;
      if (is_digit) begin
         cur_byte = (digit < 4'd10) ? (8'h30 + {4'h0, digit}) : (8'h37 + {4'h0, digit});
      end else if (idx == CR_IDX) begin
         cur_byte = 8'h0D;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      byte_start = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = SEND;
         SEND: begin
            if (!skip) begin
               byte_start = 1'b1;
               state_nxt  = WAIT;
            end
         end
         WAIT: begin
            if (byte_ready) state_nxt = (idx == FINAL_IDX) ? IDLE : SEND;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Byte is driven combinationally in the pulse cycle, then held from the register.
   assign byte_out     = (state == SEND) ? cur_byte : byte_q;
   assign result_ready = (state == IDLE) && !start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg  <= '0;
         idx    <= '0;
         cnt    <= '0;
         seen   <= 1'b0;
         byte_q <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg <= value;
                  idx   <= '0;
                  cnt   <= '0;
                  seen  <= 1'b0;
               end
            end
            SEND: begin
               if (skip) begin
                  idx   <= idx + 4'd1;
                  shreg <= shreg << 4;
               end else begin
                  byte_q <= cur_byte;
                  cnt    <= cnt + 4'd1;
                  seen   <= 1'b1;
               end
            end
            WAIT: begin
               if (byte_ready) begin
                  idx   <= idx + 4'd1;
                  shreg <= shreg << 4;
                  if (idx == FINAL_IDX) result <= cnt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_outhex32_1_1_32.sv
// Bench for outhex32_1_1_32: instance 0 prints all digits, instance 1 suppresses leading zeros.
module tb_outhex32_1_1_32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       start;
   logic [1:0][31:0] value;
   logic [1:0]       byte_ready = '0;
   logic [1:0]       byte_start;
   logic [1:0][7:0]  byte_out;
   logic [1:0][3:0]  result;
   logic [1:0]       result_ready;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   string      hexs = "0123456789ABCDEF";
   logic [7:0] exp_b [2][16];
   int         exp_n [2];
   int         exp_rd [2];
   logic [7:0] obs [2][16];
   int         obs_n [2];
   int         first_pc [2];
   int         last_pc [2];
   int         start_cyc [2];
   int         done_cyc;
   int         mode [2];
   int         dly [2];
   logic       pending [2];
   logic       prev_bs [2];
   logic [7:0] held [2];

   outhex32_1_1_32 #(.NDIGITS(8), .APPEND_CRLF(1), .SUPPRESS_LZ(0)) u_full (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .value(value[0]),
      .result(result[0]), .result_ready(result_ready[0]),
      .byte_start(byte_start[0]), .byte_out(byte_out[0]), .byte_ready(byte_ready[0]));

   outhex32_1_1_32 #(.NDIGITS(8), .APPEND_CRLF(1), .SUPPRESS_LZ(1)) u_slz (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .value(value[1]),
      .result(result[1]), .result_ready(result_ready[1]),
      .byte_start(byte_start[1]), .byte_out(byte_out[1]), .byte_ready(byte_ready[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected text: hex digits MSB first, optional leading-zero drop, then CR LF.
   task automatic model_load(input int k, input logic [31:0] v, input bit slz);
      bit seen = 0;
      int d;
      exp_n[k] = 0; exp_rd[k] = 0; obs_n[k] = 0;
      for (int i = 7; i >= 0; i--) begin
         d = int'((v >> (4*i)) & 32'hF);
         if (slz && !seen && d == 0 && i > 0) continue;
         seen = 1;
         exp_b[k][exp_n[k]] = hexs[d];
         exp_n[k]++;
      end
      exp_b[k][exp_n[k]] = 8'h0D; exp_n[k]++;
      exp_b[k][exp_n[k]] = 8'h0A; exp_n[k]++;
   endtask

   // Downstream transmitter: mode 0 never accepts, 1 always ready, 2 ready 3 cycles after each pulse.
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         case (mode[k])
            0: byte_ready[k] = 1'b0;
            1: byte_ready[k] = 1'b1;
            default: begin
               if (byte_start[k]) begin
                  dly[k] = 3;
                  byte_ready[k] = 1'b0;
               end else if (dly[k] > 0) begin
                  dly[k]--;
                  byte_ready[k] = (dly[k] == 0);
               end
            end
         endcase
      end
   end

   // Compare process: every pulse against the model, byte hold while waiting, no back-to-back pulses.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            pending[k] = 1'b0;
            prev_bs[k] = 1'b0;
         end else begin
            if (byte_start[k]) begin
               check($sformatf("pulse_spacing%0d", k), 32'(prev_bs[k]), 0);
               if (exp_rd[k] < exp_n[k]) begin
                  check($sformatf("byte%0d_%0d", k, exp_rd[k]), 32'(byte_out[k]), 32'(exp_b[k][exp_rd[k]]));
                  exp_rd[k]++;
               end else begin
                  checks++; errors++;
                  $display("FAIL extra_pulse%0d: got byte %h expected no pulse", k, byte_out[k]);
               end
               if (obs_n[k] < 16) obs[k][obs_n[k]] = byte_out[k];
               if (obs_n[k] == 0) first_pc[k] = cyc;
               last_pc[k] = cyc;
               obs_n[k]++;
               pending[k] = 1'b1;
               held[k] = byte_out[k];
            end else if (pending[k]) begin
               check($sformatf("byte_hold%0d", k), 32'(byte_out[k]), 32'(held[k]));
               if (byte_ready[k]) pending[k] = 1'b0;
            end
            prev_bs[k] = byte_start[k];
         end
      end
   end

   task automatic pulse_start(input int k, input logic [31:0] v);
      @(posedge clk); #1;
      start[k] = 1'b1; value[k] = v; start_cyc[k] = cyc;
      @(posedge clk); #1;
      start[k] = 1'b0; value[k] = ~v;
   endtask

   task automatic start_call(input int k, input logic [31:0] v, input bit slz);
      model_load(k, v, slz);
      pulse_start(k, v);
   endtask

   task automatic wait_done(input int k, input int bound);
      int n = 0;
      while (!(exp_rd[k] == exp_n[k] && result_ready[k]) && n < bound) begin
         @(negedge clk); #1;
         n++;
      end
      done_cyc = cyc;
      if (n >= bound) begin
         checks++; errors++;
         $display("FAIL timeout_done%0d: got %0d of %0d bytes expected call complete", k, exp_rd[k], exp_n[k]);
      end
   endtask

   task automatic wait_obs(input int k, input int cnt, input int bound);
      int n = 0;
      while (obs_n[k] < cnt && n < bound) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= bound) begin
         checks++; errors++;
         $display("FAIL timeout_obs%0d: got %0d bytes expected %0d", k, obs_n[k], cnt);
      end
   endtask

   task automatic check_seq(input string name, input int k, input logic [127:0] s, input int n);
      check($sformatf("%s_count", name), obs_n[k], n);
      for (int i = 0; i < n; i++)
         check($sformatf("%s_b%0d", name, i), 32'(obs[k][i]), 32'(s[8*(n-1-i) +: 8]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = '0; value = '0;
      mode[0] = 2; mode[1] = 2; dly[0] = 0; dly[1] = 0;
      obs_n[0] = 0; obs_n[1] = 0; exp_n[0] = 0; exp_n[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;
      #2;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_byte_start%0d", k), 32'(byte_start[k]), 0);
         check($sformatf("rst_byte_out%0d", k), 32'(byte_out[k]), 0);
         check($sformatf("rst_result%0d", k), 32'(result[k]), 0);
         check($sformatf("rst_result_ready%0d", k), 32'(result_ready[k]), 1);
      end
      start[0] = 1'b1; #1;
      check("rr_follows_start", 32'(result_ready[0]), 0);
      start[0] = 1'b0; #1;
      @(posedge clk); #1 rst_n = 1'b1;
      check("rr_after_release", 32'(result_ready[0]), 1);

      // Full 8-digit print with a slow transmitter.
      start_call(0, 32'h1234ABCD, 0);
      wait_done(0, 200);
      check_seq("seq_1234abcd", 0, 128'h31323334414243440D0A, 10);
      check("result_1234abcd", 32'(result[0]), 10);
      check("rr_1234abcd", 32'(result_ready[0]), 1);
      check("latency_full", first_pc[0] - start_cyc[0], 1);

      // Zero with suppression: only the last digit survives.
      start_call(1, 32'h0, 1);
      wait_done(1, 200);
      check_seq("seq_zero", 1, 128'h300D0A, 3);
      check("result_zero", 32'(result[1]), 3);
      check("latency_zero", first_pc[1] - start_cyc[1], 8);

      // Interior zeros kept.
      start_call(1, 32'h000F00A0, 1);
      wait_done(1, 200);
      check_seq("seq_f00a0", 1, 128'h46303041300D0A, 7);
      check("result_f00a0", 32'(result[1]), 7);
      check("latency_f00a0", first_pc[1] - start_cyc[1], 4);

      // A second start with a new value while busy is ignored.
      start_call(0, 32'hDEADBEEF, 0);
      wait_obs(0, 2, 100);
      pulse_start(0, 32'h11111111);
      wait_done(0, 200);
      repeat (20) @(negedge clk);
      #1;
      check_seq("seq_deadbeef", 0, 128'h44454144424545460D0A, 10);
      check("result_deadbeef", 32'(result[0]), 10);
      check("rr_deadbeef", 32'(result_ready[0]), 1);

      // Reset in the middle of a call, then a clean restart.
      start_call(0, 32'h1234ABCD, 0);
      wait_obs(0, 4, 100);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("midrst_byte_start", 32'(byte_start[0]), 0);
      check("midrst_result", 32'(result[0]), 0);
      check("midrst_byte_out", 32'(byte_out[0]), 0);
      check("midrst_result_ready", 32'(result_ready[0]), 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      start_call(0, 32'h1234ABCD, 0);
      wait_done(0, 200);
      check_seq("seq_after_rst", 0, 128'h31323334414243440D0A, 10);
      check("result_after_rst", 32'(result[0]), 10);

      // Transmitter always ready: one pulse every other cycle.
      mode[0] = 1;
      start_call(0, 32'h1234ABCD, 0);
      wait_done(0, 100);
      check("fast_count", obs_n[0], 10);
      check("fast_first", first_pc[0] - start_cyc[0], 1);
      check("fast_last", last_pc[0] - start_cyc[0], 19);
      check("fast_within_21", 32'(done_cyc - start_cyc[0] <= 21), 1);

      // Transmitter never ready: a single pulse, then hold.
      mode[0] = 0;
      start_call(0, 32'h00000005, 0);
      repeat (30) @(negedge clk);
      #1;
      check("stuck_count", obs_n[0], 1);
      check("stuck_byte", 32'(obs[0][0]), 32'h30);
      check("stuck_result_ready", 32'(result_ready[0]), 0);
      check("stuck_byte_out", 32'(byte_out[0]), 32'h30);
      rst_n = 1'b0;
      #10;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
